// File: rtl/token_word_packer.sv
// token_word_packer: packs a serial 1-bit token stream LSB-first into W-bit
// words, buffers them in a DEPTH-word FIFO and presents them on a
// valid/ready interface. Partial words can be closed early with flush.
// Words that arrive while the FIFO is full and not being popped are
// dropped, and the sticky overflow flag is set.
// Optional feature: define TOKEN_WORD_PACKER_POPCOUNT_EN to add out_ones,
// the number of 1 bits in out_word, stored in the FIFO next to each word.
module token_word_packer #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_bit,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_word,
  output logic [$clog2(W+1)-1:0] out_len,
`ifdef TOKEN_WORD_PACKER_POPCOUNT_EN
  output logic [$clog2(W+1)-1:0] out_ones,
`endif
  output logic                   overflow
);

  localparam int LENW = $clog2(W + 1);
  localparam int IDXW = $clog2(W);
  localparam int PW   = $clog2(DEPTH);
  localparam int OCW  = $clog2(DEPTH + 1);

  logic [IDXW-1:0] idx;
  logic [W-1:0]    shreg;
  logic [W-1:0]    cap_word;
  logic [LENW-1:0] cnt;
  logic            complete;
  logic            push;
  logic            pop;
  logic            full;
  logic            wr_en;
  logic            drop;

  logic [W-1:0]    mem_word [DEPTH];
  logic [LENW-1:0] mem_len  [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [OCW-1:0]  occ;

`ifdef TOKEN_WORD_PACKER_POPCOUNT_EN
  logic [LENW-1:0] mem_ones [DEPTH];
  logic [LENW-1:0] push_ones;
`endif

  // Word as it stands after this cycle's bit, its length and push decision.
  // Bits above idx are always zero, so a flushed word is already padded.
  always_comb begin
    cap_word = shreg;
    if (in_valid) cap_word[idx] = in_bit;
    cnt      = LENW'(idx) + LENW'(in_valid);
    complete = in_valid && (idx == IDXW'(W - 1));
    push     = complete || (flush && (cnt != '0));
  end

  // Packing state: restart after every push (even a dropped one).
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      shreg <= '0;
    end else if (push) begin
      idx   <= '0;
      shreg <= '0;
    end else if (in_valid) begin
      idx   <= idx + IDXW'(1);
      shreg <= cap_word;
    end
  end

  // FIFO handshake: a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    out_valid = (occ != '0);
    full      = (occ == OCW'(DEPTH));
    pop       = out_valid && out_ready;
    wr_en     = push && (!full || pop);
    drop      = push && full && !pop;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   occ <= occ + OCW'(1);
        2'b01:   occ <= occ - OCW'(1);
        default: occ <= occ;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef TOKEN_WORD_PACKER_POPCOUNT_EN
  // Ones count of the word being pushed, stored with it.
  always_comb begin
    push_ones = '0;
    for (int i = 0; i < W; i++) push_ones = push_ones + LENW'(cap_word[i]);
  end
`endif

  // FIFO storage; contents are only observed through the gated outputs.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_word[wr_ptr] <= cap_word;
      mem_len[wr_ptr]  <= cnt;
`ifdef TOKEN_WORD_PACKER_POPCOUNT_EN
      mem_ones[wr_ptr] <= push_ones;
`endif
    end
  end

  // Head of FIFO, forced to zero while empty.
  always_comb begin
    out_word = out_valid ? mem_word[rd_ptr] : '0;
    out_len  = out_valid ? mem_len[rd_ptr]  : '0;
`ifdef TOKEN_WORD_PACKER_POPCOUNT_EN
    out_ones = out_valid ? mem_ones[rd_ptr] : '0;
`endif
  end

endmodule

// File: tb/tb_token_word_packer.sv
// Testbench for token_word_packer (W=8, DEPTH=2). A reference model keeps
// pending stream bits and queued words as plain queues and is advanced on
// every rising edge from the same inputs the DUT sees.
module tb_token_word_packer;

  localparam int W     = 8;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_word;
  logic [3:0] out_len;
  logic       overflow;
`ifdef TOKEN_WORD_PACKER_POPCOUNT_EN
  logic [3:0] out_ones;
`endif

  int checks = 0;
  int failures = 0;

  // reference model state
  bit         mb[$];
  logic [7:0] mw[$];
  int         ml[$];
  bit         m_ovf = 0;

  token_word_packer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_len(out_len),
`ifdef TOKEN_WORD_PACKER_POPCOUNT_EN
    .out_ones(out_ones),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock: update the model from current inputs, then sample
  // point is 1 time unit after the edge.
  task automatic tick();
    bit         do_pop, was_full, do_push;
    logic [7:0] w;
    int         len;
    @(posedge clk);
    if (rst) begin
      mb.delete(); mw.delete(); ml.delete(); m_ovf = 0;
    end else begin
      do_pop   = (mw.size() > 0) && out_ready;
      was_full = (mw.size() == DEPTH);
      if (in_valid) mb.push_back(in_bit);
      do_push = (mb.size() == W) || (flush && mb.size() > 0);
      w = 8'h00; len = 0;
      if (do_push) begin
        len = mb.size();
        for (int i = 0; i < len; i++) w[i] = mb[i];
        mb.delete();
      end
      if (do_pop) begin
        void'(mw.pop_front()); void'(ml.pop_front());
      end
      if (do_push) begin
        if (!was_full || do_pop) begin
          mw.push_back(w); ml.push_back(len);
        end else m_ovf = 1;
      end
    end
    #1;
  endtask

  task automatic send(input bit v, input bit b, input bit f, input bit r);
    in_valid = v; in_bit = b; flush = f; out_ready = r;
    tick();
    in_valid = 0; flush = 0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit r);
    for (int i = 0; i < 8; i++) send(1, w[i], 0, r);
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; flush = 0; out_ready = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_word !== 8'h00 || out_len !== 4'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset: valid=%b word=%h len=%0d ovf=%b, required 0/00/0/0",
               out_valid, out_word, out_len, overflow);
    end
  endtask

  task automatic test_full_word();
    logic [7:0] pat;
    pat = 8'b1000_1101;
    send_word(pat, 1);
    checks++;
    if (out_valid !== 1'b1 || out_word !== 8'h8D || out_len !== 4'd8) begin
      failures++;
      $display("FAIL full_word: valid=%b word=%h len=%0d, required 1/8d/8", out_valid, out_word, out_len);
    end
`ifdef TOKEN_WORD_PACKER_POPCOUNT_EN
    checks++;
    if (out_ones !== 4'd4) begin
      failures++;
      $display("FAIL full_word_ones: got %0d required 4", out_ones);
    end
`endif
    send(0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_word_pop: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    send(1, 1, 0, 1); send(1, 1, 0, 1); send(1, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_partial_hidden: valid=%b required 0", out_valid);
    end
    send(0, 0, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || out_word !== 8'h03 || out_len !== 4'd3) begin
      failures++;
      $display("FAIL flush_word: valid=%b word=%h len=%0d, required 1/03/3", out_valid, out_word, out_len);
    end
    send(0, 0, 1, 1);
    send(0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_empty: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] w1, w2, w3;
    w1 = 8'($urandom); w2 = 8'($urandom); w3 = 8'($urandom);
    send_word(w1, 0); send_word(w2, 0);
    checks++;
    if (out_valid !== 1'b1 || out_word !== w1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_full: valid=%b word=%h ovf=%b, required 1/%h/0", out_valid, out_word, overflow, w1);
    end
    send_word(w3, 0);
    checks++;
    if (out_word !== w1 || out_len !== 4'd8 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drop: word=%h len=%0d ovf=%b, required %h/8/1", out_word, out_len, overflow, w1);
    end
    send(0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_word !== w2) begin
      failures++;
      $display("FAIL ovf_second: valid=%b word=%h, required 1/%h", out_valid, out_word, w2);
    end
    send(0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drained: valid=%b ovf=%b, required 0/1", out_valid, overflow);
    end
    do_reset();
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_reset: ovf=%b required 0", overflow);
    end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] w1, w2, w3;
    w1 = 8'($urandom); w2 = 8'($urandom); w3 = 8'($urandom);
    send_word(w1, 0); send_word(w2, 0);
    for (int i = 0; i < 7; i++) send(1, w3[i], 0, 0);
    send(1, w3[7], 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_word !== w2 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL pushpop_head: valid=%b word=%h ovf=%b, required 1/%h/0", out_valid, out_word, overflow, w2);
    end
    send(0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_word !== w3 || out_len !== 4'd8) begin
      failures++;
      $display("FAIL pushpop_third: valid=%b word=%h len=%0d, required 1/%h/8", out_valid, out_word, out_len, w3);
    end
    send(0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL pushpop_end: valid=%b ovf=%b, required 0/0", out_valid, overflow);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) send(1, 1'($urandom), 0, 1);
    do_reset();
    for (int i = 0; i < 7; i++) send(1, 1, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_no_partial: valid=%b word=%h, required valid 0", out_valid, out_word);
    end
    send(1, 1, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_word !== 8'hFF || out_len !== 4'd8) begin
      failures++;
      $display("FAIL midrst_word: valid=%b word=%h len=%0d, required 1/ff/8", out_valid, out_word, out_len);
    end
    send(0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_single: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_random();
    int bad;
    bit exp_v;
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      send(1'(c % 2 == 0), 1'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom));
      exp_v = (mw.size() > 0);
      checks++;
      if (out_valid !== exp_v || overflow !== m_ovf ||
          (exp_v && (out_word !== mw[0] || out_len !== 4'(ml[0])))) begin
        failures++; bad++;
        if (bad < 10)
          $display("FAIL random c=%0d: valid=%b word=%h len=%0d ovf=%b, required %b/%h/%0d/%b",
                   c, out_valid, out_word, out_len, overflow, exp_v,
                   exp_v ? mw[0] : 8'h00, exp_v ? ml[0] : 0, m_ovf);
      end
`ifdef TOKEN_WORD_PACKER_POPCOUNT_EN
      checks++;
      if (out_ones !== (exp_v ? 4'($countones(mw[0])) : 4'd0)) begin
        failures++;
        $display("FAIL random_ones c=%0d: got %0d", c, out_ones);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_overflow();
    test_push_pop_full();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/token_word_packer.md
Name: token_word_packer

Overview:
- Downstream consumer of the serial token-reduction stages. Takes a 1-bit token stream (one bit per valid cycle) and packs it into W-bit words.
- Words are buffered in a small FIFO and presented on a valid/ready interface to parallel logic (counters, bus writers).
- Supports early flush of a partial word and sticky overflow reporting.

Parameters:
- W, 8, packed word width in bits; legal range 2..32.
- DEPTH, 2, output FIFO depth in words; power of two, 2..8.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_bit carries a stream bit this cycle.
- in_bit  input  1  serial token bit.
- flush  input  1  one-cycle pulse: close the current partial word.
- out_valid  output  1  FIFO head word available.
- out_ready  input  1  consumer accepts the head word this cycle.
- out_word  output  W  head word; bit 0 is the first bit received.
- out_len  output  $clog2(W+1)  number of real stream bits in out_word (W for a full word).
- overflow  output  1  sticky: at least one word dropped since reset.

Behaviour:
- Reset (rst=1 at clk edge): bit index 0, shift register 0, FIFO empty, out_valid=0, out_word=0, out_len=0, overflow=0. Reset mid-word discards the partial word with no output.
- Bit capture:
  - On each cycle with in_valid=1, store in_bit at position idx, then idx++.
  - The first bit received lands in bit 0 (LSB-first).
  - in_valid=0 cycles hold all packing state.
- Word completion: the bit accepted at idx=W-1 completes the word.
  - The word is pushed with len=W and idx returns to 0.
  - Next-bit capture restarts at bit 0 on the following valid cycle.
  - No bubble is required between words.
- Flush, with flush=1 this cycle:
  - If in_valid=1, that bit is captured first.
  - If the resulting count is 0 (idx=0 and no bit this cycle, or a word just completed), nothing extra is pushed.
  - Otherwise the partial word is pushed, zero-padded in the upper bits, with len=count; idx returns to 0.
- Single push per cycle: a completion and a flush in the same cycle produce one push only (the full word).
- Latency: a pushed word appears on out_valid exactly one cycle after the capture edge when the FIFO was empty.
- FIFO and handshake:
  - Pop occurs when out_valid & out_ready.
  - out_word, out_len and out_valid are registered/FIFO outputs, stable while out_valid=1 and out_ready=0.
  - out_ready while out_valid=0 is ignored.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full; occupancy is unchanged.
- Overflow: a push when the FIFO is full and no pop occurs that cycle is dropped.
  - overflow is set from the next cycle and held until rst.
  - The packing counter still resets, so the next word starts clean.
- Full/empty:
  - Occupancy counter 0..DEPTH; pointers wrap modulo DEPTH.
  - out_valid = (occupancy != 0).
- out_len width is $clog2(W+1), so W is representable.

Optional Feature:
- Macro: TOKEN_WORD_PACKER_POPCOUNT_EN.
- Defined:
  - Adds output out_ones, width $clog2(W+1): count of 1 bits in out_word.
  - Computed at push time and stored in the FIFO alongside the word, so it is valid and stable exactly as out_word is.
  - Zero at reset and when out_valid=0.
- Undefined: the port and its FIFO storage are absent; all other behaviour is identical.

Test Plan:
- W=8, out_ready=1, stream 1,0,1,1,0,0,0,1 on consecutive valid cycles -> one cycle after the last bit, out_valid=1, out_word=8'h8D, out_len=8 (out_ones=4 with the macro defined).
- W=8: 3 bits 1,1,0 then flush pulse with in_valid=0 -> out_word=8'h03, out_len=3. A subsequent flush with no bits produces no word.
- W=8, DEPTH=2, out_ready=0, stream 24 bits (3 words) -> first two words held stable, third dropped, overflow=1. Then out_ready=1 -> exactly the first two words pop in order; overflow stays 1.
- FIFO full with out_ready=1 in the same cycle a word completes -> pop and push both occur, no drop, overflow stays 0, output order preserved.
- in_valid toggled 1/0 every cycle with a random stream, random out_ready -> every output word equals the scoreboard's LSB-first packing; no loss when out_ready is never low more than DEPTH words.
- rst asserted after 5 of 8 bits, then 8 fresh bits 0xFF -> single output word 8'hFF, len=8; the partial bits never appear.
